// File: rtl/spi_master.sv
// ============================================================================
// spi_master: 16-bit mode-0 SPI master framing {address, readWrite, data}.
// Revision 1.0
// ============================================================================
`default_nettype none

module spi_master #(
   parameter int CLK_DIV = 16,
   parameter int CS_GAP  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       readWrite,
   input  logic [6:0] address,
   input  logic [7:0] writeData,
   output logic       busy,
   output logic       done,
   output logic [7:0] readData,
   output logic       sclk_pin,
   output logic       cs_pin,
   output logic       mosi_pin,
   input  logic       miso_pin
);

   localparam int MAX_CNT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int DW      = $clog2(MAX_CNT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LAST = DW'(CS_GAP - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      HOLD  = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [DW-1:0]   div_cnt, div_cnt_n;
   logic [3:0]      bit_cnt, bit_cnt_n;
   logic [15:0]     frame, frame_n;
   logic [7:0]      rx_sr, rx_sr_n;
   logic            is_read, is_read_n;
   logic            miso_meta, miso_sync;
   logic            busy_n, done_n, sclk_n, cs_n, mosi_n;
   logic [7:0]      read_data_n;

   always_comb begin
      state_n     = state;
      div_cnt_n   = div_cnt;
      bit_cnt_n   = bit_cnt;
      frame_n     = frame;
      rx_sr_n     = rx_sr;
      is_read_n   = is_read;
      busy_n      = busy;
      done_n      = 1'b0;
      sclk_n      = sclk_pin;
      cs_n        = cs_pin;
      mosi_n      = mosi_pin;
      read_data_n = readData;

      case (state)
         IDLE: begin
            if (start) begin
               state_n   = SHIFT;
               frame_n   = {address, readWrite, (readWrite ? 8'h00 : writeData)};
               mosi_n    = address[6];
               is_read_n = readWrite;
               cs_n      = 1'b0;
               busy_n    = 1'b1;
               sclk_n    = 1'b0;
               div_cnt_n = '0;
               bit_cnt_n = 4'd0;
            end
         end
         SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               if (!sclk_pin) begin
                  sclk_n = 1'b1;
               end else begin
                  // End of a high phase: capture miso for the data byte, then advance.
                  if (bit_cnt[3]) begin
                     rx_sr_n = {rx_sr[6:0], miso_sync};
                  end
                  sclk_n = 1'b0;
                  if (bit_cnt == 4'd15) begin
                     state_n = HOLD;
                     mosi_n  = 1'b0;
                  end else begin
                     bit_cnt_n = bit_cnt + 4'd1;
                     frame_n   = {frame[14:0], 1'b0};
                     mosi_n    = frame[14];
                  end
               end
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
         HOLD: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_n = '0;
               cs_n      = 1'b1;
               state_n   = GAP;
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
         GAP: begin
            if (div_cnt == GAP_LAST) begin
               div_cnt_n = '0;
               state_n   = DONE;
               done_n    = 1'b1;
               busy_n    = 1'b0;
               if (is_read) begin
                  read_data_n = rx_sr;
               end
            end else begin
               div_cnt_n = div_cnt + DW'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= 4'd0;
         frame     <= 16'h0000;
         rx_sr     <= 8'h00;
         is_read   <= 1'b0;
         miso_meta <= 1'b0;
         miso_sync <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sclk_pin  <= 1'b0;
         cs_pin    <= 1'b1;
         mosi_pin  <= 1'b0;
         readData  <= 8'h00;
      end else begin
         state     <= state_n;
         div_cnt   <= div_cnt_n;
         bit_cnt   <= bit_cnt_n;
         frame     <= frame_n;
         rx_sr     <= rx_sr_n;
         is_read   <= is_read_n;
         miso_meta <= miso_pin;
         miso_sync <= miso_meta;
         busy      <= busy_n;
         done      <= done_n;
         sclk_pin  <= sclk_n;
         cs_pin    <= cs_n;
         mosi_pin  <= mosi_n;
         readData  <= read_data_n;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// tb_spi_master: table-driven checks of spi_master plus reset/back-to-back cases.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_spi_master;

   localparam int CD1 = 16;
   localparam int CG1 = 16;
   localparam int CD2 = 2;
   localparam int CG2 = 4;

   logic clk = 1'b0;
   logic reset;
   logic start1, rw1, miso1;
   logic [6:0] addr1;
   logic [7:0] wd1;
   logic busy1, done1, sclk1, cs1, mosi1;
   logic [7:0] rd1;
   logic start2, rw2, miso2;
   logic [6:0] addr2;
   logic [7:0] wd2;
   logic busy2, done2, sclk2, cs2, mosi2;
   logic [7:0] rd2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_master #(.CLK_DIV(CD1), .CS_GAP(CG1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .readWrite(rw1),
      .address(addr1), .writeData(wd1), .busy(busy1), .done(done1),
      .readData(rd1), .sclk_pin(sclk1), .cs_pin(cs1), .mosi_pin(mosi1),
      .miso_pin(miso1)
   );

   spi_master #(.CLK_DIV(CD2), .CS_GAP(CG2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .readWrite(rw2),
      .address(addr2), .writeData(wd2), .busy(busy2), .done(done2),
      .readData(rd2), .sclk_pin(sclk2), .cs_pin(cs2), .mosi_pin(mosi2),
      .miso_pin(miso2)
   );

   // Slave: shifts its byte out MSB first on the falling edges that end bits 8..15.
   int         fall_cnt = 0;
   logic [7:0] slave_byte = 8'h00;
   always @(negedge sclk1) begin
      fall_cnt = fall_cnt + 1;
      if (fall_cnt >= 8 && fall_cnt < 16) miso1 = slave_byte[15 - fall_cnt];
      else                                miso1 = 1'b0;
   end

   typedef struct {
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  slave;
      bit          mid;
      logic [15:0] exp_frame;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t vecs[4];

   logic [15:0] mon_frame;
   logic [7:0]  mon_rd;
   int mon_rises, mon_cslow, mon_done_at, mon_done_cnt, mon_busy_err, mon_period_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input bit sel, input vec_t v, input int half);
      logic prev_sclk, s, c, m, b, d;
      logic [7:0] rdv;
      int last_rise;
      mon_frame = 16'h0; mon_rises = 0; mon_cslow = 0; mon_done_at = -1;
      mon_done_cnt = 0; mon_rd = 8'hxx; mon_busy_err = 0; mon_period_err = 0;
      last_rise = -1;
      fall_cnt = 0;
      slave_byte = v.slave;
      @(negedge clk);
      if (sel) begin start2 = 1'b1; rw2 = v.rw; addr2 = v.addr; wd2 = v.wdata; end
      else     begin start1 = 1'b1; rw1 = v.rw; addr1 = v.addr; wd1 = v.wdata; end
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      prev_sclk = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         s   = sel ? sclk2 : sclk1;
         c   = sel ? cs2   : cs1;
         m   = sel ? mosi2 : mosi1;
         b   = sel ? busy2 : busy1;
         d   = sel ? done2 : done1;
         rdv = sel ? rd2   : rd1;
         if (s && !prev_sclk) begin
            mon_frame = {mon_frame[14:0], m};
            mon_rises++;
            if (last_rise >= 0 && (n - last_rise) != 2 * half) mon_period_err++;
            last_rise = n;
         end
         prev_sclk = s;
         if (!c) mon_cslow++;
         if (d) begin
            mon_done_cnt++;
            if (mon_done_at < 0) begin mon_done_at = n; mon_rd = rdv; end
            if (b) mon_busy_err++;
         end else if (mon_done_at < 0 && !b) begin
            mon_busy_err++;
         end
         if (v.mid && !sel) begin
            if (n == 100) begin start1 = 1'b1; addr1 = 7'h11; wd1 = 8'hFF; rw1 = ~v.rw; end
            if (n == 101) start1 = 1'b0;
         end
         if (mon_done_at >= 0 && n >= mon_done_at + 20) break;
         @(negedge clk);
      end
   endtask

   initial begin
      vec_t v2;
      int rises, cnt, bad, n_rise, n_fall, n_done;
      logic prev_c, prev_s;

      // rw, addr, wdata, slave byte, mid-start pulse, expected frame, expected readData
      vecs[0] = '{1'b0, 7'h05, 8'hA5, 8'h00, 1'b0, 16'h0AA5, 8'h00};
      vecs[1] = '{1'b1, 7'h05, 8'h77, 8'h3C, 1'b0, 16'h0B00, 8'h3C};
      vecs[2] = '{1'b0, 7'h7F, 8'h5A, 8'h96, 1'b1, 16'hFE5A, 8'h3C};
      vecs[3] = '{1'b1, 7'h00, 8'hEE, 8'hC3, 1'b0, 16'h0100, 8'hC3};

      reset = 1'b1;
      start1 = 1'b0; rw1 = 1'b0; addr1 = 7'h0; wd1 = 8'h0;
      start2 = 1'b0; rw2 = 1'b0; addr2 = 7'h0; wd2 = 8'h0; miso2 = 1'b0;
      miso1 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_cs", cs1, 1'b1);
      check("reset_sclk", sclk1, 1'b0);
      check("reset_mosi", mosi1, 1'b0);
      check("reset_busy", busy1, 1'b0);
      check("reset_done", done1, 1'b0);
      check("reset_readData", rd1, 8'h00);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_txn(1'b0, vecs[i], CD1);
         check($sformatf("v%0d_frame", i), mon_frame, vecs[i].exp_frame);
         check($sformatf("v%0d_rises", i), mon_rises, 16);
         check($sformatf("v%0d_period", i), mon_period_err, 0);
         check($sformatf("v%0d_cs_low", i), mon_cslow, 33 * CD1);
         check($sformatf("v%0d_done_at", i), mon_done_at, 33 * CD1 + CG1);
         check($sformatf("v%0d_done_cnt", i), mon_done_cnt, 1);
         check($sformatf("v%0d_busy", i), mon_busy_err, 0);
         check($sformatf("v%0d_readData", i), mon_rd, vecs[i].exp_rd);
      end

      // Fast divider instance: 4-cycle SCLK period, 66-cycle CS window.
      v2 = '{1'b0, 7'h2A, 8'h81, 8'h00, 1'b0, 16'h5481, 8'h00};
      run_txn(1'b1, v2, CD2);
      check("div2_frame", mon_frame, 16'h5481);
      check("div2_rises", mon_rises, 16);
      check("div2_period", mon_period_err, 0);
      check("div2_cs_low", mon_cslow, 33 * CD2);
      check("div2_done_at", mon_done_at, 33 * CD2 + CG2);

      // Back-to-back with start held high.
      @(negedge clk);
      start1 = 1'b1; rw1 = 1'b0; addr1 = 7'h05; wd1 = 8'hA5;
      @(negedge clk);
      n_rise = -1; n_fall = -1; n_done = -1; prev_c = 1'b0;
      for (int n = 0; n < 2000 && n_fall < 0; n++) begin
         if (done1 && n_done < 0) n_done = n;
         if (cs1 && !prev_c && n_rise < 0) n_rise = n;
         if (!cs1 && prev_c && n_rise >= 0) n_fall = n;
         prev_c = cs1;
         @(negedge clk);
      end
      start1 = 1'b0;
      check("b2b_cs_gap", n_fall - n_rise, CG1 + 2);
      check("b2b_gap_min", (n_fall - n_rise) >= CG1, 1'b1);
      check("b2b_accept_after_done", n_fall - n_done, 2);
      cnt = 0;
      for (int n = 0; n < 700 && cnt == 0; n++) begin
         if (done1) cnt++;
         @(negedge clk);
      end
      check("b2b_second_done", cnt, 1);

      // Reset after the 5th rising SCLK edge aborts the frame.
      @(negedge clk);
      start1 = 1'b1; rw1 = 1'b1; addr1 = 7'h33;
      @(negedge clk);
      start1 = 1'b0;
      rises = 0; prev_s = 1'b0;
      for (int n = 0; n < 1000 && rises < 5; n++) begin
         if (sclk1 && !prev_s) rises++;
         prev_s = sclk1;
         if (rises < 5) @(negedge clk);
      end
      check("abort_rises_seen", rises, 5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_cs", cs1, 1'b1);
      check("abort_sclk", sclk1, 1'b0);
      check("abort_busy", busy1, 1'b0);
      check("abort_readData", rd1, 8'h00);
      cnt = 0;
      for (int n = 0; n < 700; n++) begin
         if (done1) cnt++;
         @(negedge clk);
      end
      check("abort_no_done", cnt, 0);

      // Reset and start in the same cycle: start is dropped.
      reset = 1'b1; start1 = 1'b1;
      @(negedge clk);
      reset = 1'b0; start1 = 1'b0;
      bad = 0;
      for (int n = 0; n < 20; n++) begin
         if (!cs1 || busy1) bad++;
         @(negedge clk);
      end
      check("reset_start_dropped", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
